// File: rtl/updi_pkg.sv
// Shared UPDI definitions: response-handler state encoding and protocol byte constants.
package updi_pkg;

  typedef enum logic [1:0] {
    UPDI_RESP_HDLR_IDLE,
    UPDI_RESP_HDLR_RX_DATA,
    UPDI_RESP_HDLR_RX_ACK
  } updi_resp_hdlr_state_e;

  localparam logic [7:0] UPDI_ACK   = 8'h40;
  localparam logic [7:0] UPDI_SYNCH = 8'h55;

endpackage

// File: rtl/updi_timeout_counter.sv
// Idle-gap counter: counts enabled cycles since the last clear and pulses o_expired
// on the TIMEOUT_CYCLES-th one.
module updi_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_BITS        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_BITS-1:0] LIMIT = TO_BITS'(TIMEOUT_CYCLES - 1);

  logic [TO_BITS-1:0] r_cnt;

  assign o_expired = i_enable & ~i_clear & (r_cnt == LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_expired) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updi_response_handler.sv
// UPDI receive path: drains the RX FIFO into a response buffer and checks ACK bytes,
// reporting done/ack/error/timeout pulses to the programmer control FSM.
module updi_response_handler
  import updi_pkg::*;
#(
  parameter int unsigned MAX_DATA_SIZE  = 16,
  parameter int unsigned LEN_BITS       = $clog2(MAX_DATA_SIZE + 1),
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned TO_BITS        = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic [LEN_BITS-1:0]        i_rx_len,
  input  logic                       i_ack_req,
  output logic                       o_ready,
  output logic [8*MAX_DATA_SIZE-1:0] o_rx_data,
  output logic [LEN_BITS-1:0]        o_rx_count,
  output logic                       o_done,
  output logic                       o_ack_received,
  output logic                       o_ack_error,
  output logic                       o_timeout,
  input  logic [7:0]                 i_fifo_data,
  output logic                       o_fifo_rd_en,
  input  logic                       i_fifo_empty
);

  localparam logic [LEN_BITS-1:0] MAX_LEN = LEN_BITS'(MAX_DATA_SIZE);

  updi_resp_hdlr_state_e r_state;
  logic [7:0]            r_rx_data [MAX_DATA_SIZE];
  logic [LEN_BITS-1:0]   r_len;

  logic                w_pop_data;
  logic                w_pop_ack;
  logic                w_to_clear;
  logic                w_to_enable;
  logic                w_expired;
  logic [LEN_BITS-1:0] w_len_clamped;
  logic [LEN_BITS-1:0] w_count_inc;

  assign w_len_clamped = (i_rx_len > MAX_LEN) ? MAX_LEN : i_rx_len;
  assign w_count_inc   = o_rx_count + 1'b1;

  // The FIFO is first-word-fall-through, so the pop must coincide with the capture edge.
  assign w_pop_data   = (r_state == UPDI_RESP_HDLR_RX_DATA) && !i_fifo_empty;
  assign w_pop_ack    = (r_state == UPDI_RESP_HDLR_RX_ACK) && i_ack_req && !i_fifo_empty;
  assign o_fifo_rd_en = w_pop_data | w_pop_ack;

  assign w_to_clear  = (r_state == UPDI_RESP_HDLR_IDLE) || o_fifo_rd_en;
  assign w_to_enable = i_fifo_empty && ((r_state == UPDI_RESP_HDLR_RX_DATA) ||
                                        ((r_state == UPDI_RESP_HDLR_RX_ACK) && i_ack_req));

  updi_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_BITS        (TO_BITS)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_to_clear),
    .i_enable  (w_to_enable),
    .o_expired (w_expired)
  );

  always_comb begin
    o_rx_data = '0;
    for (int unsigned i = 0; i < MAX_DATA_SIZE; i++) begin
      o_rx_data[8*i +: 8] = r_rx_data[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= UPDI_RESP_HDLR_IDLE;
      o_ready        <= 1'b0;
      for (int unsigned i = 0; i < MAX_DATA_SIZE; i++) r_rx_data[i] <= 8'h00;
      o_rx_count     <= '0;
      r_len          <= '0;
      o_done         <= 1'b0;
      o_ack_received <= 1'b0;
      o_ack_error    <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      o_done         <= 1'b0;
      o_ack_received <= 1'b0;
      o_ack_error    <= 1'b0;
      o_timeout      <= 1'b0;
      unique case (r_state)
        UPDI_RESP_HDLR_IDLE: begin
          o_ready <= 1'b1;
          // start has priority; a held ack_req is picked up once the transfer completes
          if (i_start) begin
            o_rx_count <= '0;
            if (w_len_clamped == '0) begin
              o_done <= 1'b1;
            end else begin
              r_len   <= w_len_clamped;
              r_state <= UPDI_RESP_HDLR_RX_DATA;
              o_ready <= 1'b0;
            end
          end else if (i_ack_req) begin
            r_state <= UPDI_RESP_HDLR_RX_ACK;
            o_ready <= 1'b0;
          end
        end
        UPDI_RESP_HDLR_RX_DATA: begin
          if (w_pop_data) begin
            for (int unsigned i = 0; i < MAX_DATA_SIZE; i++) begin
              if (o_rx_count == LEN_BITS'(i)) r_rx_data[i] <= i_fifo_data;
            end
            o_rx_count <= w_count_inc;
            if (w_count_inc == r_len) begin
              o_done  <= 1'b1;
              r_state <= UPDI_RESP_HDLR_IDLE;
              o_ready <= 1'b1;
            end
          end else if (w_expired) begin
            o_timeout <= 1'b1;
            r_state   <= UPDI_RESP_HDLR_IDLE;
            o_ready   <= 1'b1;
          end
        end
        UPDI_RESP_HDLR_RX_ACK: begin
          if (!i_ack_req) begin
            r_state <= UPDI_RESP_HDLR_IDLE;
            o_ready <= 1'b1;
          end else if (w_pop_ack) begin
            o_ack_received <= (i_fifo_data == UPDI_ACK);
            o_ack_error    <= (i_fifo_data != UPDI_ACK);
            r_state        <= UPDI_RESP_HDLR_IDLE;
            o_ready        <= 1'b1;
          end else if (w_expired) begin
            o_timeout <= 1'b1;
            r_state   <= UPDI_RESP_HDLR_IDLE;
            o_ready   <= 1'b1;
          end
        end
        default: begin
          r_state <= UPDI_RESP_HDLR_IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updi_response_handler.sv
// Self-checking bench for updi_response_handler: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model with a queue-based RX FIFO.
module tb_updi_response_handler;

  localparam int unsigned MAXD = 16;
  localparam int unsigned LENB = 5;
  localparam int unsigned TO   = 8;

  logic            clk        = 1'b0;
  logic            rst_n      = 1'b0;
  logic            start      = 1'b0;
  logic [LENB-1:0] rx_len     = '0;
  logic            ack_req    = 1'b0;
  logic [7:0]      fifo_data  = 8'h00;
  logic            fifo_empty = 1'b1;

  logic              o_ready, o_done, o_ack_received, o_ack_error, o_timeout, o_fifo_rd_en;
  logic [8*MAXD-1:0] o_rx_data;
  logic [LENB-1:0]   o_rx_count;

  always #5 clk = ~clk;

  updi_response_handler #(
    .MAX_DATA_SIZE  (MAXD),
    .LEN_BITS       (LENB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_rx_len       (rx_len),
    .i_ack_req      (ack_req),
    .o_ready        (o_ready),
    .o_rx_data      (o_rx_data),
    .o_rx_count     (o_rx_count),
    .o_done         (o_done),
    .o_ack_received (o_ack_received),
    .o_ack_error    (o_ack_error),
    .o_timeout      (o_timeout),
    .i_fifo_data    (fifo_data),
    .o_fifo_rd_en   (o_fifo_rd_en),
    .i_fifo_empty   (fifo_empty)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // RX FIFO contents; the model consumes bytes at the edge where a pop must occur
  logic [7:0] q[$];

  // Model: mode 0 = waiting, 1 = collecting data, 2 = waiting for ACK
  int         m_mode   = 0;
  int         m_target = 0;
  int         m_gap    = 0;
  int         m_count  = 0;
  logic       m_ready  = 1'b0;
  logic       m_done   = 1'b0;
  logic       m_ackr   = 1'b0;
  logic       m_acke   = 1'b0;
  logic       m_to     = 1'b0;
  logic [7:0] m_data [MAXD];

  initial for (int i = 0; i < MAXD; i++) m_data[i] = 8'h00;

  function automatic logic exp_pop();
    return !fifo_empty && ((m_mode == 1) || (m_mode == 2 && ack_req));
  endfunction

  function automatic logic [127:0] exp_data();
    logic [127:0] v = '0;
    for (int i = 0; i < MAXD; i++) v[8*i +: 8] = m_data[i];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_target = 0; m_gap = 0; m_count = 0;
    m_ready = 0; m_done = 0; m_ackr = 0; m_acke = 0; m_to = 0;
    for (int i = 0; i < MAXD; i++) m_data[i] = 8'h00;
  endtask

  task automatic model_step();
    int n;
    logic [7:0] b;
    m_done = 0; m_ackr = 0; m_acke = 0; m_to = 0;
    if (m_mode == 0) begin
      if (start) begin
        n = (int'(rx_len) > MAXD) ? MAXD : int'(rx_len);
        m_count = 0;
        if (n == 0) m_done = 1;
        else begin m_target = n; m_mode = 1; m_gap = 0; end
      end else if (ack_req) begin
        m_mode = 2; m_gap = 0;
      end
    end else if (m_mode == 1) begin
      if (!fifo_empty) begin
        b = q.pop_front();
        m_data[m_count] = b;
        m_count++;
        m_gap = 0;
        if (m_count == m_target) begin m_done = 1; m_mode = 0; end
      end else begin
        m_gap++;
        if (m_gap == TO) begin m_to = 1; m_mode = 0; end
      end
    end else begin
      if (!ack_req) m_mode = 0;
      else if (!fifo_empty) begin
        b = q.pop_front();
        if (b == 8'h40) m_ackr = 1; else m_acke = 1;
        m_mode = 0;
      end else begin
        m_gap++;
        if (m_gap == TO) begin m_to = 1; m_mode = 0; end
      end
    end
    m_ready = (m_mode == 0);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    chk("ready", o_ready, m_ready);
    chk("rx_count", o_rx_count, m_count);
    chk("rx_data", o_rx_data, exp_data());
    chk("done", o_done, m_done);
    chk("ack_received", o_ack_received, m_ackr);
    chk("ack_error", o_ack_error, m_acke);
    chk("timeout", o_timeout, m_to);
    chk("fifo_rd_en", o_fifo_rd_en, exp_pop());
  end

  task automatic sync_fifo();
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    sync_fifo();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    sync_fifo();
  endtask

  task automatic wait_done(input string name, output int lat);
    lat = 1;
    tick();
    while (!o_done && lat < 40) begin tick(); lat++; end
    if (!o_done) chk({name, "_done_seen"}, 0, 1);
  endtask

  task automatic wait_ack_pulse(input string name);
    int k = 0;
    while (!(o_ack_received || o_ack_error || o_timeout) && k < 40) begin tick(); k++; end
    if (!(o_ack_received || o_ack_error || o_timeout)) chk({name, "_pulse_seen"}, 0, 1);
  endtask

  initial begin
    int lat;
    int c;

    // Reset state
    repeat (2) tick();
    chk("rst_ready", o_ready, 0);
    chk("rst_count", o_rx_count, 0);
    chk("rst_data", o_rx_data, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", o_ready, 1);

    // Pre-filled three-byte response
    push(8'h1E); push(8'h95); push(8'h0C);
    start = 1'b1; rx_len = 5'd3;
    wait_done("t1", lat);
    start = 1'b0;
    chk("t1_latency", lat, 4);
    chk("t1_byte0", o_rx_data[7:0], 8'h1E);
    chk("t1_byte1", o_rx_data[15:8], 8'h95);
    chk("t1_byte2", o_rx_data[23:16], 8'h0C);
    chk("t1_count", o_rx_count, 3);
    chk("t1_ready", o_ready, 1);
    chk("t1_fifo_left", q.size(), 0);
    tick();

    // Good ACK arrives after a gap
    ack_req = 1'b1;
    repeat (6) tick();
    push(8'h40);
    wait_ack_pulse("t2");
    chk("t2_ack_received", o_ack_received, 1);
    chk("t2_ack_error", o_ack_error, 0);
    ack_req = 1'b0;
    repeat (3) tick();

    // Bad ACK byte
    ack_req = 1'b1;
    tick();
    push(8'h00);
    wait_ack_pulse("t3");
    chk("t3_ack_error", o_ack_error, 1);
    chk("t3_ack_received", o_ack_received, 0);
    ack_req = 1'b0;
    repeat (3) tick();

    // Short response ends in timeout
    push(8'hAA);
    start = 1'b1; rx_len = 5'd2;
    tick();
    start = 1'b0;
    chk("t4_pop", o_fifo_rd_en, 1);
    c = 0;
    while (!o_timeout && c < 40) begin tick(); c++; end
    chk("t4_edges_after_pop", c - 1, TO);
    chk("t4_count", o_rx_count, 1);
    chk("t4_done", o_done, 0);
    tick();

    // Zero-length start, then start and ack_req together
    start = 1'b1; rx_len = 5'd0;
    tick();
    start = 1'b0;
    chk("t5_done_len0", o_done, 1);
    chk("t5_count_len0", o_rx_count, 0);
    chk("t5_ready_len0", o_ready, 1);
    tick();
    push(8'h5A); push(8'hA5); push(8'h40);
    start = 1'b1; rx_len = 5'd2; ack_req = 1'b1;
    wait_done("t5", lat);
    start = 1'b0;
    chk("t5_data_first0", o_rx_data[7:0], 8'h5A);
    chk("t5_data_first1", o_rx_data[15:8], 8'hA5);
    chk("t5_no_ack_yet", o_ack_received, 0);
    tick();
    wait_ack_pulse("t5");
    chk("t5_ack_after", o_ack_received, 1);
    ack_req = 1'b0;
    repeat (3) tick();

    // Reset after one of four bytes
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    start = 1'b1; rx_len = 5'd4;
    tick();
    start = 1'b0;
    tick();
    chk("t6_count_before", o_rx_count, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", o_ready, 0);
    chk("t6_rst_count", o_rx_count, 0);
    chk("t6_rst_data", o_rx_data, 0);
    chk("t6_rst_rd_en", o_fifo_rd_en, 0);
    chk("t6_rst_done", o_done, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_ready_after", o_ready, 1);
    chk("t6_fifo_left", q.size(), 3);
    chk("t6_fifo_head", fifo_data, 8'h22);
    start = 1'b1; rx_len = 5'd3;
    wait_done("t6", lat);
    start = 1'b0;
    chk("t6_drain", o_rx_data[23:0], 24'h443322);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      tick();
      if ($urandom_range(0, 2) == 0 && q.size() < 24) begin
        if ($urandom_range(0, 2) == 0) push(8'h40);
        else push(8'($urandom_range(0, 255)));
      end
      start  = ($urandom_range(0, 7) == 0);
      rx_len = LENB'($urandom_range(0, 20));
      if ($urandom_range(0, 11) == 0) ack_req = ~ack_req;
    end
    start = 1'b0; ack_req = 1'b0;
    repeat (TO + 20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
